me_ref_reader: RTL and testbench

- Read-side counterpart of the reference-window memory writer.
- Given a candidate motion vector, fetches the 16x16 candidate block from the 32x32 reference window memory (128 x 64-bit words, 4 words per row, pixel 0 in byte [7:0]).
- Realigns each unaligned 16-pixel row and streams it to the SAD datapath over a valid/ready handshake.
- Sits inside Me_engine between the reference memory read port and the SAD array.

---
 rtl/me_ref_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_me_ref_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/me_ref_reader.sv
// me_ref_reader
// Fetches a 16x16 candidate block from the 32x32 reference window memory
// (128 x 64-bit words, 4 words per row, pixel 0 in byte [7:0]). Each source
// row is read as 2 or 3 words, realigned to the candidate column and handed
// to the SAD datapath over a valid/ready handshake.
// Build option: define ME_REF_PREFETCH_EN to add a second row buffer so that
// reads for the next row overlap the hand-off of the current one. Without
// it, each row is fully read, assembled and accepted before the next starts.
module me_ref_reader (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [4:0]   mv_x,
  input  logic [4:0]   mv_y,
  output logic [6:0]   address_read_ref,
  output logic         read_enable_ref,
  input  logic [63:0]  data_read_ref,
  output logic [127:0] row_data,
  output logic [3:0]   row_index,
  output logic         row_last,
  output logic         row_valid,
  input  logic         row_ready,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int BLK    = 16;
  localparam int WIN    = 32;
  localparam int MV_MAX = WIN - BLK;

  localparam logic [3:0] LAST_ROW = 4'(BLK - 1);
  localparam logic [4:0] MV_LIMIT = 5'(MV_MAX);

  // Concatenate the fetched words and drop the sub-word pixel offset.
  function automatic logic [127:0] realign(input logic [63:0] w0,
                                           input logic [63:0] w1,
                                           input logic [63:0] w2,
                                           input logic [2:0]  frac);
    logic [191:0] cat;
    cat = {w2, w1, w0} >> {frac, 3'b000};
    return cat[127:0];
  endfunction

  // An 8-pixel-aligned row spans exactly two words, otherwise three.
  function automatic logic [1:0] word_count(input logic [2:0] frac);
    return (frac == 3'd0) ? 2'd2 : 2'd3;
  endfunction

  // First word address of block row 'row'; mv_y+row never exceeds 31.
  function automatic logic [6:0] row_addr(input logic [4:0] y,
                                          input logic [3:0] row,
                                          input logic [4:0] x);
    logic [4:0] src;
    src = y + {1'b0, row};
    return {src, x[4:3]};
  endfunction

  function automatic logic mv_bad(input logic [4:0] x, input logic [4:0] y);
    return (x > MV_LIMIT) || (y > MV_LIMIT);
  endfunction

  logic [4:0]   mv_x_r;
  logic [4:0]   mv_y_r;
  logic [1:0]   iss_idx_r;     // word index of the read issued this cycle
  logic         rd_pend_r;     // a read was issued last cycle, data is on the bus
  logic [1:0]   rd_idx_r;      // word index of that returning data
  logic [63:0]  word0_r;
  logic [63:0]  word1_r;
  logic [63:0]  word2_r;
  logic [63:0]  w0_s;
  logic [63:0]  w1_s;
  logic [63:0]  w2_s;
  logic [1:0]   n_s;
  logic         last_issue_s;
  logic [127:0] row_s;

  // Row assembly: the final word is taken straight from the read bus.
  always_comb begin
    n_s          = word_count(mv_x_r[2:0]);
    last_issue_s = read_enable_ref && (iss_idx_r == (n_s - 2'd1));
    w0_s         = (rd_pend_r && (rd_idx_r == 2'd0)) ? data_read_ref : word0_r;
    w1_s         = (rd_pend_r && (rd_idx_r == 2'd1)) ? data_read_ref : word1_r;
    w2_s         = (rd_pend_r && (rd_idx_r == 2'd2)) ? data_read_ref : word2_r;
    row_s        = realign(w0_s, w1_s, w2_s, mv_x_r[2:0]);
  end

  // Capture each returned word into its slot of the assembly buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_r <= 1'b0;
      rd_idx_r  <= 2'd0;
      word0_r   <= 64'd0;
      word1_r   <= 64'd0;
      word2_r   <= 64'd0;
    end else begin
      rd_pend_r <= read_enable_ref;
      rd_idx_r  <= iss_idx_r;
      if (rd_pend_r) begin
        case (rd_idx_r)
          2'd0:    word0_r <= data_read_ref;
          2'd1:    word1_r <= data_read_ref;
          2'd2:    word2_r <= data_read_ref;
          default: word2_r <= word2_r;
        endcase
      end
    end
  end

`ifndef ME_REF_PREFETCH_EN

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] state_r;
  logic [3:0] row_r;

  // Serialized request sequencer: read a row, assemble it, hand it off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= S_IDLE;
      row_r            <= 4'd0;
      mv_x_r           <= 5'd0;
      mv_y_r           <= 5'd0;
      iss_idx_r        <= 2'd0;
      address_read_ref <= 7'd0;
      read_enable_ref  <= 1'b0;
      row_data         <= 128'd0;
      row_index        <= 4'd0;
      row_last         <= 1'b0;
      row_valid        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (go) begin
            busy <= 1'b1;
            if (mv_bad(mv_x, mv_y)) begin
              done    <= 1'b1;
              err     <= 1'b1;
              state_r <= S_DONE;
            end else begin
              mv_x_r           <= mv_x;
              mv_y_r           <= mv_y;
              row_r            <= 4'd0;
              iss_idx_r        <= 2'd0;
              address_read_ref <= row_addr(mv_y, 4'd0, mv_x);
              read_enable_ref  <= 1'b1;
              state_r          <= S_READ;
            end
          end
        end
        S_READ: begin
          if (last_issue_s) begin
            read_enable_ref <= 1'b0;
            state_r         <= S_WAIT;
          end else begin
            iss_idx_r        <= iss_idx_r + 2'd1;
            address_read_ref <= address_read_ref + 7'd1;
          end
        end
        S_WAIT: begin
          row_data  <= row_s;
          row_index <= row_r;
          row_last  <= (row_r == LAST_ROW);
          row_valid <= 1'b1;
          state_r   <= S_OUT;
        end
        S_OUT: begin
          if (row_ready) begin
            row_valid <= 1'b0;
            row_last  <= 1'b0;
            if (row_r == LAST_ROW) begin
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              row_r            <= row_r + 4'd1;
              iss_idx_r        <= 2'd0;
              address_read_ref <= row_addr(mv_y_r, row_r + 4'd1, mv_x_r);
              read_enable_ref  <= 1'b1;
              state_r          <= S_READ;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          read_enable_ref <= 1'b0;
          row_valid       <= 1'b0;
          row_last        <= 1'b0;
          busy            <= 1'b0;
          done            <= 1'b0;
          err             <= 1'b0;
          state_r         <= S_IDLE;
        end
      endcase
    end
  end

`else

  logic         req_r;          // valid request in progress
  logic [4:0]   rd_row_r;       // next row to read; 16 once all are issued
  logic [1:0]   alloc_r;        // rows started but not yet accepted (max 2)
  logic [3:0]   asm_row_r;      // index of the next row to be assembled
  logic         rd_last_r;      // returning word closes its row
  logic [127:0] spare_data_r;
  logic [3:0]   spare_idx_r;
  logic         spare_valid_r;
  logic         accept_s;
  logic         new_row_s;
  logic         start_s;
  logic [1:0]   alloc_s;

  // Row start is allowed only while a buffer slot is guaranteed for it.
  always_comb begin
    accept_s  = row_valid && row_ready;
    new_row_s = rd_pend_r && rd_last_r;
    alloc_s   = alloc_r - {1'b0, accept_s};
    start_s   = req_r && (rd_row_r != 5'd16) &&
                (!read_enable_ref || last_issue_s) && (alloc_s != 2'd2);
  end

  // Tag each returning word with whether it closes its row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_last_r <= 1'b0;
    end else begin
      rd_last_r <= last_issue_s;
    end
  end

  // Overlapped reader plus two-deep row buffer (output register + spare).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_r            <= 1'b0;
      rd_row_r         <= 5'd0;
      alloc_r          <= 2'd0;
      asm_row_r        <= 4'd0;
      mv_x_r           <= 5'd0;
      mv_y_r           <= 5'd0;
      iss_idx_r        <= 2'd0;
      spare_data_r     <= 128'd0;
      spare_idx_r      <= 4'd0;
      spare_valid_r    <= 1'b0;
      address_read_ref <= 7'd0;
      read_enable_ref  <= 1'b0;
      row_data         <= 128'd0;
      row_index        <= 4'd0;
      row_last         <= 1'b0;
      row_valid        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (done) begin
        busy <= 1'b0;
      end
      if (!busy && go) begin
        busy <= 1'b1;
        if (mv_bad(mv_x, mv_y)) begin
          done <= 1'b1;
          err  <= 1'b1;
        end else begin
          req_r     <= 1'b1;
          mv_x_r    <= mv_x;
          mv_y_r    <= mv_y;
          rd_row_r  <= 5'd0;
          asm_row_r <= 4'd0;
        end
      end

      if (start_s) begin
        address_read_ref <= row_addr(mv_y_r, rd_row_r[3:0], mv_x_r);
        read_enable_ref  <= 1'b1;
        iss_idx_r        <= 2'd0;
        rd_row_r         <= rd_row_r + 5'd1;
      end else if (last_issue_s) begin
        read_enable_ref <= 1'b0;
      end else if (read_enable_ref) begin
        iss_idx_r        <= iss_idx_r + 2'd1;
        address_read_ref <= address_read_ref + 7'd1;
      end
      alloc_r <= alloc_s + {1'b0, start_s};

      if (new_row_s) begin
        asm_row_r <= asm_row_r + 4'd1;
      end

      if (accept_s) begin
        if (spare_valid_r) begin
          row_data      <= spare_data_r;
          row_index     <= spare_idx_r;
          row_last      <= (spare_idx_r == LAST_ROW);
          spare_valid_r <= new_row_s;
          if (new_row_s) begin
            spare_data_r <= row_s;
            spare_idx_r  <= asm_row_r;
          end
        end else if (new_row_s) begin
          row_data  <= row_s;
          row_index <= asm_row_r;
          row_last  <= (asm_row_r == LAST_ROW);
        end else begin
          row_valid <= 1'b0;
          row_last  <= 1'b0;
        end
        if (row_last) begin
          req_r <= 1'b0;
          done  <= 1'b1;
        end
      end else if (new_row_s) begin
        if (row_valid) begin
          spare_data_r  <= row_s;
          spare_idx_r   <= asm_row_r;
          spare_valid_r <= 1'b1;
        end else begin
          row_data  <= row_s;
          row_index <= asm_row_r;
          row_last  <= (asm_row_r == LAST_ROW);
          row_valid <= 1'b1;
        end
      end
    end
  end

`endif

endmodule

// File: tb/tb_me_ref_reader.sv
// Self-checking bench for me_ref_reader (default, non-prefetch build).
// Rows are predicted directly from the pixel array: row i pixel j is
// pix[mv_y+i][mv_x+j]; read counts and addresses come from the word rule.
module tb_me_ref_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [4:0]   mv_x;
  logic [4:0]   mv_y;
  logic [6:0]   address_read_ref;
  logic         read_enable_ref;
  logic [63:0]  data_read_ref = '0;
  logic [127:0] row_data;
  logic [3:0]   row_index;
  logic         row_last;
  logic         row_valid;
  logic         row_ready;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  me_ref_reader dut (
    .clk(clk), .reset(reset), .go(go), .mv_x(mv_x), .mv_y(mv_y),
    .address_read_ref(address_read_ref), .read_enable_ref(read_enable_ref),
    .data_read_ref(data_read_ref), .row_data(row_data), .row_index(row_index),
    .row_last(row_last), .row_valid(row_valid), .row_ready(row_ready),
    .busy(busy), .done(done), .err(err)
  );

  logic [7:0]  pix [0:31][0:31];
  logic [63:0] mem [0:127];

  // Reference memory: one-cycle read latency.
  always @(posedge clk) begin
    if (read_enable_ref) data_read_ref <= mem[address_read_ref];
  end

  int n_pass = 0;
  int n_total = 0;

  logic [127:0] got_row[$];
  int           got_idx[$];
  logic [6:0]   rd_addr[$];
  int done_cyc, first_cyc, err_at_done, bad_last, unstable, reads_in_out;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) pix[r][c] = 8'((r * 32 + c) & 255);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) pix[r][c] = 8'($urandom);
  endtask

  task automatic build_mem();
    for (int r = 0; r < 32; r++)
      for (int w = 0; w < 4; w++)
        for (int b = 0; b < 8; b++) mem[r*4+w][8*b +: 8] = pix[r][8*w+b];
  endtask

  function automatic logic [127:0] exp_row(input int mx, input int my, input int i);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = pix[my+i][mx+j];
    return r;
  endfunction

  function automatic logic [127:0] row_at(input int i);
    return (i < got_row.size()) ? got_row[i] : 128'd0;
  endfunction

  function automatic logic [6:0] addr_at(input int i);
    return (i < rd_addr.size()) ? rd_addr[i] : 7'd0;
  endfunction

  // Issue one request and record everything the DUT does until done.
  task automatic run_req(input int mx, input int my, input int stall_row,
                         input int stall_len, input bit rand_rdy, input bit poke);
    int cyc;
    int stall_left;
    bit holding;
    logic [127:0] hold_data;
    logic [3:0] hold_idx;
    got_row.delete(); got_idx.delete(); rd_addr.delete();
    done_cyc = -1; first_cyc = -1; err_at_done = 0;
    bad_last = 0; unstable = 0; reads_in_out = 0;
    stall_left = stall_len; holding = 0; hold_data = '0; hold_idx = '0;
    @(negedge clk);
    mv_x = 5'(mx); mv_y = 5'(my); go = 1'b1; row_ready = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 3000) begin
      if (read_enable_ref) begin
        rd_addr.push_back(address_read_ref);
        if (row_valid) reads_in_out++;
      end
      if (done) begin done_cyc = cyc; err_at_done = int'(err); end
      if (row_valid && first_cyc < 0) first_cyc = cyc;
      if (row_last && !(row_valid && row_index == 4'd15)) bad_last++;
      if (holding && (!row_valid || row_data !== hold_data || row_index !== hold_idx)) unstable++;
      if (row_valid && stall_row >= 0 && int'(row_index) == stall_row && stall_left > 0) begin
        row_ready = 1'b0; stall_left--;
      end else if (rand_rdy) row_ready = 1'($urandom_range(0, 1));
      else row_ready = 1'b1;
      holding = row_valid && !row_ready;
      hold_data = row_data; hold_idx = row_index;
      if (row_valid && row_ready) begin
        got_row.push_back(row_data); got_idx.push_back(int'(row_index));
      end
      if (poke && cyc == 10) begin go = 1'b1; mv_x = 5'd1; mv_y = 5'd1; end
      else if (poke && cyc == 11) begin go = 1'b0; mv_x = 5'(mx); mv_y = 5'(my); end
      @(negedge clk);
      cyc++;
    end
    row_ready = 1'b1;
  endtask

  // Compare a recorded run against the pixel model.
  task automatic check_run(input string tag, input int mx, input int my, input int exp_done);
    int n, bad_rows, bad_idx, bad_addr, k;
    n = (mx % 8 == 0) ? 2 : 3;
    bad_rows = 0; bad_idx = 0; bad_addr = 0; k = 0;
    check({tag, " done_seen"}, done_cyc >= 0, 1);
    if (exp_done > 0) begin
      check({tag, " done_cycle"}, done_cyc, exp_done);
      check({tag, " first_row_cycle"}, first_cyc, n + 2);
    end
    check({tag, " err_low"}, err_at_done, 0);
    check({tag, " row_count"}, got_row.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (row_at(i) !== exp_row(mx, my, i)) bad_rows++;
      if (i >= got_idx.size() || got_idx[i] != i) bad_idx++;
    end
    check({tag, " row_data"}, bad_rows, 0);
    check({tag, " row_index_seq"}, bad_idx, 0);
    check({tag, " read_count"}, rd_addr.size(), 16 * n);
    for (int i = 0; i < 16; i++)
      for (int w = 0; w < n; w++) begin
        if (addr_at(k) !== 7'((my + i) * 4 + mx / 8 + w)) bad_addr++;
        k++;
      end
    check({tag, " read_addrs"}, bad_addr, 0);
    check({tag, " row_last_only_15"}, bad_last, 0);
    check({tag, " stable_when_stalled"}, unstable, 0);
    check({tag, " no_reads_in_out"}, reads_in_out, 0);
    check({tag, " idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int found;
    int nreads;
    int mx, my;
    reset = 1'b1; go = 1'b0; row_ready = 1'b1; mv_x = '0; mv_y = '0;
    fill_pattern(); build_mem();
    repeat (3) @(negedge clk);
    check("reset_outputs", {address_read_ref, read_enable_ref, row_data, row_index,
                            row_last, row_valid, busy, done, err}, 160'd0);
    reset = 1'b0;

    run_req(0, 0, -1, 0, 0, 0);
    check_run("mv00", 0, 0, 65);
    check("mv00_row0", row_at(0), 128'h0F0E0D0C0B0A09080706050403020100);
    check("mv00_row15_px0", row_at(15) & 128'hFF, 128'hE0);

    run_req(5, 3, -1, 0, 0, 1);
    check_run("mv53_poke", 5, 3, 81);
    check("mv53_px0", row_at(0) & 128'hFF, 128'h65);
    check("mv53_px15", row_at(0) >> 120, 128'h74);
    check("mv53_addr0", {addr_at(0), addr_at(1), addr_at(2)}, {7'd12, 7'd13, 7'd14});

    run_req(16, 16, -1, 0, 0, 0);
    check_run("mv1616", 16, 16, 65);
    check("mv1616_px0", row_at(0) & 128'hFF, 128'h10);
    check("mv1616_addr0", {addr_at(0), addr_at(1)}, {7'd66, 7'd67});
    check("mv1616_row15_px15", row_at(15) >> 120, 128'hFF);
    check("mv1616_last_addr", addr_at(rd_addr.size() - 1), 7'd127);

    run_req(0, 0, 7, 5, 0, 0);
    check_run("stall_r7", 0, 0, 70);

    // Out-of-range vectors: one-cycle done+err, no reads.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      mv_x = (t == 0) ? 5'd17 : 5'd2; mv_y = (t == 0) ? 5'd0 : 5'd20; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      nreads = int'(read_enable_ref);
      check("bad_mv_done", {done, err}, 2'b11);
      @(negedge clk);
      nreads += int'(read_enable_ref);
      check("bad_mv_after", {done, err, busy}, 3'b000);
      check("bad_mv_reads", nreads, 0);
    end

    // Reset while row 4 is being held by the consumer.
    @(negedge clk);
    mv_x = 5'd0; mv_y = 5'd0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (row_valid && row_index == 4'd4) begin row_ready = 1'b0; found = 1; end
      else begin row_ready = 1'b1; @(negedge clk); end
    end
    check("reset_row4_reached", found, 1);
    #2 reset = 1'b1;
    #1 check("reset_midrun_outputs", {address_read_ref, read_enable_ref, row_data, row_index,
                                      row_last, row_valid, busy, done, err}, 160'd0);
    @(negedge clk);
    reset = 1'b0; row_ready = 1'b1;
    run_req(0, 0, -1, 0, 0, 0);
    check_run("after_reset", 0, 0, 65);

    // Random window contents and vectors.
    for (int t = 0; t < 4; t++) begin
      fill_random(); build_mem();
      mx = $urandom_range(0, 16); my = $urandom_range(0, 16);
      if (t == 3) begin
        run_req(mx, my, -1, 0, 1, 0);
        check_run("rand_bp", mx, my, 0);
      end else begin
        run_req(mx, my, -1, 0, 0, 0);
        check_run("rand", mx, my, 16 * ((mx % 8 == 0) ? 4 : 5) + 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
